spi_cmd_master: RTL and testbench

SPI mode-0 initiator that issues one command frame per request to the board's SPI command slave (opcode byte, then payload) and captures the full-duplex response bytes.
- Serves as the on-FPGA host for FPGA-to-FPGA links and as the stimulus master in system benches.
- Frame format and opcodes (0x10/0x11/0x12 writes, 0x20/0x21/0x22/0x30 reads) are owned by the slave side; this block is opcode-agnostic and only moves bytes.

---
 rtl/spi_cmd_pkg.sv | 40 ++++
 rtl/spi_cmd_master_if.sv | 23 ++
 rtl/spi_clk_divider.sv | 34 +++
 rtl/spi_cmd_master.sv | 153 +++++++++++++++
 tb/tb_spi_cmd_master.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_cmd_pkg.sv
// Shared constants and types for the SPI command link: slave opcodes,
// command-byte field layout, frame limits and the master FSM encoding.
package spi_cmd_pkg;

    localparam int MAX_BYTES = 10;

    localparam logic [7:0] CMD_WR_PITCH     = 8'h10;
    localparam logic [7:0] CMD_WR_YAW       = 8'h11;
    localparam logic [7:0] CMD_WR_BOTH      = 8'h12;
    localparam logic [7:0] CMD_RD_POS_PITCH = 8'h20;
    localparam logic [7:0] CMD_RD_POS_YAW   = 8'h21;
    localparam logic [7:0] CMD_RD_POS_BOTH  = 8'h22;
    localparam logic [7:0] CMD_RD_PWM       = 8'h30;

    // Command byte: enable, direction, then the top nibble of the duty value.
    localparam int CMD_EN_BIT     = 7;
    localparam int CMD_DIR_BIT    = 6;
    localparam int CMD_DUTY_HI    = 5;
    localparam int CMD_DUTY_LO    = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOW,
        ST_HIGH,
        ST_HOLD,
        ST_GAP,
        ST_DONE
    } state_t;

    function automatic logic [3:0] clamp_nbytes(input logic [3:0] n);
        if (n == 4'd0)
            return 4'd1;
        else if (int'(n) > MAX_BYTES)
            return 4'(MAX_BYTES);
        else
            return n;
    endfunction

endpackage

// File: rtl/spi_cmd_master_if.sv
// Request/response bundle between a frame requester and spi_cmd_master.
interface spi_cmd_master_if;
    import spi_cmd_pkg::*;

    logic                         start;
    logic [7:0]                   opcode;
    logic [3:0]                   nbytes;
    logic [8*(MAX_BYTES-1)-1:0]   tx_payload;
    logic [8*MAX_BYTES-1:0]       rx_data;
    logic                         busy;
    logic                         done;

    modport master (
        output start, opcode, nbytes, tx_payload,
        input  rx_data, busy, done
    );

    modport slave (
        input  start, opcode, nbytes, tx_payload,
        output rx_data, busy, done
    );

endinterface

// File: rtl/spi_clk_divider.sv
// Half-period counter for SCLK; strobes rise/fall on the last cycle of each
// low/high half while enabled, and parks at the start of a low half otherwise.
module spi_clk_divider #(
    parameter int HALF = 12
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic rise,
    output logic fall
);
    localparam int CNT_W = $clog2(HALF);

    logic [CNT_W-1:0] cnt;
    logic             phase_high;
    logic             tc;

    assign tc   = en && (cnt == '0);
    assign rise = tc && !phase_high;
    assign fall = tc && phase_high;

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            cnt        <= CNT_W'(HALF - 1);
            phase_high <= 1'b0;
        end else if (cnt == '0) begin
            cnt        <= CNT_W'(HALF - 1);
            phase_high <= !phase_high;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/spi_cmd_master.sv
// SPI mode-0 initiator: sends opcode + payload in one CS frame and captures
// the full-duplex response bytes.
//
// state    | meaning
// IDLE     | waiting for start, CS high
// SETUP    | CS low, first bit on PICO, before first SCLK rise
// LOW      | SCLK low half-period
// HIGH     | SCLK high half-period
// HOLD     | CS still low after last SCLK fall
// GAP      | CS high, end-of-message guard for the slave
// DONE     | one-cycle done pulse
module spi_cmd_master
    import spi_cmd_pkg::*;
#(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int SCLK_FREQ = 1_000_000,
    parameter int CS_SETUP  = 8,
    parameter int CS_HOLD   = 8,
    parameter int CS_GAP    = 16
) (
    input  logic            clk,
    input  logic            reset,
    spi_cmd_master_if.slave cmd,
    output logic            SPI_CLK,
    output logic            SPI_PICO,
    output logic            SPI_CS,
    input  logic            SPI_POCI
);
    localparam int HALF  = CLK_FREQ / (2 * SCLK_FREQ);
    localparam int TMR_W = 16;

    if (HALF < 8) begin : g_half_check
        $error("spi_cmd_master: HALF=%0d too small for POCI sampling margin", HALF);
    end

    state_t                     state, state_nxt;
    logic [TMR_W-1:0]           tmr;
    logic [2:0]                 bit_cnt;
    logic [3:0]                 byte_cnt;
    logic [3:0]                 n_lat;
    logic [7:0]                 tx_sr;
    logic [7:0]                 rx_sr;
    logic [8*(MAX_BYTES-1)-1:0] tx_buf;
    logic [8*MAX_BYTES-1:0]     rx_q;
    logic                       poci_meta, poci_sync;
    logic                       sclk_en, rise, fall;
    logic                       tmr_tc, last_bit;
    logic                       busy_q, done_q;

    assign sclk_en  = (state == ST_LOW) || (state == ST_HIGH);
    assign tmr_tc   = (tmr == '0);
    assign last_bit = (bit_cnt == 3'd7) && (byte_cnt == n_lat - 4'd1);

    spi_clk_divider #(.HALF(HALF)) u_div (
        .clk   (clk),
        .reset (reset),
        .en    (sclk_en),
        .rise  (rise),
        .fall  (fall)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (cmd.start) state_nxt = ST_SETUP;
            ST_SETUP: if (tmr_tc)    state_nxt = ST_LOW;
            ST_LOW:   if (rise)      state_nxt = ST_HIGH;
            ST_HIGH:  if (fall)      state_nxt = last_bit ? ST_HOLD : ST_LOW;
            ST_HOLD:  if (tmr_tc)    state_nxt = ST_GAP;
            ST_GAP:   if (tmr_tc)    state_nxt = ST_DONE;
            ST_DONE:                 state_nxt = ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    // Pin and status flops follow the next state so they change on the same
    // edge as the FSM without any decode glitches on the board.
    always_ff @(posedge clk) begin
        if (reset) begin
            poci_meta <= 1'b0;
            poci_sync <= 1'b0;
            tmr       <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            n_lat     <= 4'd1;
            tx_sr     <= '0;
            rx_sr     <= '0;
            tx_buf    <= '0;
            rx_q      <= '0;
            SPI_CS    <= 1'b1;
            SPI_CLK   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            poci_meta <= SPI_POCI;
            poci_sync <= poci_meta;
            SPI_CS    <= !(state_nxt inside {ST_SETUP, ST_LOW, ST_HIGH, ST_HOLD});
            SPI_CLK   <= (state_nxt == ST_HIGH);
            busy_q    <= (state_nxt != ST_IDLE);
            done_q    <= (state_nxt == ST_DONE);

            if (state_nxt != state) begin
                case (state_nxt)
                    ST_SETUP: tmr <= TMR_W'(CS_SETUP - 1);
                    ST_HOLD:  tmr <= TMR_W'(CS_HOLD - 1);
                    ST_GAP:   tmr <= TMR_W'(CS_GAP - 1);
                    default:  tmr <= '0;
                endcase
            end else if (!tmr_tc) begin
                tmr <= tmr - 1'b1;
            end

            if (state == ST_IDLE && cmd.start) begin
                n_lat    <= clamp_nbytes(cmd.nbytes);
                tx_buf   <= cmd.tx_payload;
                tx_sr    <= cmd.opcode;
                rx_q     <= '0;
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end

            if (rise)
                rx_sr <= {rx_sr[6:0], poci_sync};

            if (fall) begin
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt == 3'd7)
                    rx_q[8*byte_cnt +: 8] <= rx_sr;
                if (last_bit) begin
                    tx_sr <= '0;
                end else if (bit_cnt == 3'd7) begin
                    byte_cnt <= byte_cnt + 1'b1;
                    tx_sr    <= tx_buf[8*byte_cnt +: 8];
                end else begin
                    tx_sr <= {tx_sr[6:0], 1'b0};
                end
            end
        end
    end

    assign SPI_PICO    = tx_sr[7];
    assign cmd.rx_data = rx_q;
    assign cmd.busy    = busy_q;
    assign cmd.done    = done_q;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Scoreboard bench for spi_cmd_master: loopback frames plus a behavioural
// command slave (pitch position readback, pitch write with duty saturation).
module tb_spi_cmd_master;
    import spi_cmd_pkg::*;

    localparam int CLK_FREQ  = 25_000_000;
    localparam int SCLK_FREQ = 1_000_000;
    localparam int CS_SETUP  = 8;
    localparam int CS_HOLD   = 8;
    localparam int CS_GAP    = 16;
    localparam int HALF      = CLK_FREQ / (2 * SCLK_FREQ);

    typedef struct {
        logic [8*MAX_BYTES-1:0] rx;
        int                     len;
        int                     rises;
        int                     cs_low;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic spi_clk, spi_pico, spi_cs, spi_poci;
    logic loopback = 1'b0;
    logic sl_poci = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int rise_total = 0, cs_low_total = 0, done_total = 0;
    logic mon_sclk = 1'b0;
    exp_t sb[$];

    spi_cmd_master_if cmd();

    spi_cmd_master #(
        .CLK_FREQ  (CLK_FREQ),
        .SCLK_FREQ (SCLK_FREQ),
        .CS_SETUP  (CS_SETUP),
        .CS_HOLD   (CS_HOLD),
        .CS_GAP    (CS_GAP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd      (cmd),
        .SPI_CLK  (spi_clk),
        .SPI_PICO (spi_pico),
        .SPI_CS   (spi_cs),
        .SPI_POCI (spi_poci)
    );

    assign spi_poci = loopback ? spi_pico : sl_poci;

    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (spi_clk && !mon_sclk) rise_total <= rise_total + 1;
        mon_sclk <= spi_clk;
        if (!spi_cs) cs_low_total <= cs_low_total + 1;
        if (cmd.done) done_total <= done_total + 1;
    end

    // Command slave model: samples PICO on SCLK rise, updates POCI shortly
    // after SCLK fall, commits pitch writes when CS rises.
    logic       sl_sclk_q = 1'b0, sl_cs_q = 1'b1;
    int         sl_bits = 0;
    logic [7:0] sl_sh = 8'h00;
    logic [7:0] sl_rx [16];
    logic [7:0] sl_resp [16];
    logic       sl_en = 1'b0, sl_dir = 1'b0;
    logic [11:0] sl_duty = 12'h000;

    always @(posedge clk) begin
        logic [11:0] raw;
        logic [31:0] pos;
        pos = 32'h1234_5678;
        if (!spi_cs && sl_cs_q) begin
            sl_bits = 0;
            for (int i = 0; i < 16; i++) sl_resp[i] = 8'h00;
            sl_poci <= 1'b0;
        end else if (!spi_cs) begin
            if (spi_clk && !sl_sclk_q) begin
                sl_sh = {sl_sh[6:0], spi_pico};
                sl_bits++;
                if (sl_bits % 8 == 0 && sl_bits <= 128) sl_rx[sl_bits/8 - 1] = sl_sh;
                if (sl_bits == 8 && sl_sh == CMD_RD_POS_PITCH)
                    for (int k = 1; k <= 4; k++) sl_resp[k] = pos[8*(4-k) +: 8];
            end else if (!spi_clk && sl_sclk_q) begin
                sl_poci <= (sl_bits < 128) ? sl_resp[sl_bits/8][7 - sl_bits%8] : 1'b0;
            end
        end else if (spi_cs && !sl_cs_q) begin
            if (sl_bits >= 24 && sl_rx[0] == CMD_WR_PITCH) begin
                sl_en  = sl_rx[1][CMD_EN_BIT];
                sl_dir = sl_rx[1][CMD_DIR_BIT];
                raw    = {sl_rx[1][CMD_DUTY_HI:CMD_DUTY_LO], sl_rx[2]};
                // the PWM stage is 10-bit; larger requests saturate
                sl_duty = (raw > 12'h3FF) ? 12'h3FF : raw;
            end
            sl_poci <= 1'b0;
        end
        sl_sclk_q = spi_clk;
        sl_cs_q   = spi_cs;
    end

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] op, input logic [3:0] nb,
                             input logic [8*(MAX_BYTES-1)-1:0] pay, input bit loop,
                             input int poke_at);
        exp_t e;
        int n_eff, t0, r0, c0, d0, n;
        logic [7:0] fb;
        logic [31:0] pos;
        pos = 32'h1234_5678;
        n_eff = (nb == 4'd0) ? 1 : ((int'(nb) > MAX_BYTES) ? MAX_BYTES : int'(nb));
        e.rx = '0;
        for (int k = 0; k < n_eff; k++) begin
            if (loop) begin
                if (k == 0) fb = op;
                else        fb = pay[8*(k-1) +: 8];
            end else if (op == CMD_RD_POS_PITCH && k >= 1 && k <= 4) begin
                fb = pos[8*(4-k) +: 8];
            end else begin
                fb = 8'h00;
            end
            e.rx[8*k +: 8] = fb;
        end
        e.len    = 1 + CS_SETUP + 16*HALF*n_eff + CS_HOLD + CS_GAP;
        e.rises  = 8 * n_eff;
        e.cs_low = CS_SETUP + 16*HALF*n_eff + CS_HOLD;
        sb.push_back(e);

        @(negedge clk);
        loopback       = loop;
        cmd.opcode     = op;
        cmd.nbytes     = nb;
        cmd.tx_payload = pay;
        cmd.start      = 1'b1;
        t0 = cyc; r0 = rise_total; c0 = cs_low_total; d0 = done_total;
        @(negedge clk);
        cmd.start = 1'b0;
        n = 0;
        while (cmd.done !== 1'b1 && n < 5000) begin
            cmd.start = (poke_at > 0 && n == poke_at);
            if (cmd.start) begin
                cmd.opcode = CMD_RD_PWM;
                cmd.nbytes = 4'd1;
            end
            @(negedge clk);
            n++;
        end
        cmd.start = 1'b0;
        chk({tag, " done"}, cmd.done, 1);

        e = sb.pop_front();
        chk({tag, " rx"},     cmd.rx_data, e.rx);
        chk({tag, " len"},    cyc - t0, e.len);
        chk({tag, " rises"},  rise_total - r0, e.rises);
        chk({tag, " cs_low"}, cs_low_total - c0, e.cs_low);

        if (poke_at > 0) begin
            cmd.start = 1'b1;
            @(negedge clk);
            cmd.start = 1'b0;
            chk({tag, " busy_after_done"}, cmd.busy, 0);
            repeat (60) @(negedge clk);
            chk({tag, " done_count"}, done_total - d0, 1);
            chk({tag, " cs_idle"}, spi_cs, 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, r0, d0;
        cmd.start      = 1'b0;
        cmd.opcode     = 8'h00;
        cmd.nbytes     = 4'd0;
        cmd.tx_payload = '0;
        repeat (5) @(negedge clk);
        chk("rst cs",   spi_cs,      1);
        chk("rst sclk", spi_clk,     0);
        chk("rst pico", spi_pico,    0);
        chk("rst busy", cmd.busy,    0);
        chk("rst done", cmd.done,    0);
        chk("rst rx",   cmd.rx_data, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        run_frame("loop3", 8'hA5, 4'd3, {56'h0, 8'hF0, 8'h3C}, 1'b1, 0);
        run_frame("rd_pitch", CMD_RD_POS_PITCH, 4'd5, '0, 1'b0, 0);
        run_frame("wr_pitch", CMD_WR_PITCH, 4'd3, {56'h0, 8'hCF, 8'hFF}, 1'b0, 0);
        chk("wr_pitch enable", sl_en,   1);
        chk("wr_pitch dir",    sl_dir,  1);
        chk("wr_pitch duty",   sl_duty, 12'h3FF);
        run_frame("busy_poke", 8'h5A, 4'd2, {64'h0, 8'hC3}, 1'b1, 50);
        run_frame("nb0", 8'h81, 4'd0, 72'hFF_EE_DD_CC_BB_AA_99_88_77, 1'b1, 0);
        run_frame("nb15", 8'h01, 4'd15, 72'h99_88_77_66_55_44_33_22_11, 1'b1, 0);

        @(negedge clk);
        loopback       = 1'b1;
        cmd.opcode     = 8'hA5;
        cmd.nbytes     = 4'd3;
        cmd.tx_payload = {56'h0, 8'hF0, 8'h3C};
        cmd.start      = 1'b1;
        r0 = rise_total; d0 = done_total;
        @(negedge clk);
        cmd.start = 1'b0;
        n = 0;
        while (rise_total - r0 < 13 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("midrst rise13", rise_total - r0, 13);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst cs",   spi_cs,      1);
        chk("midrst sclk", spi_clk,     0);
        chk("midrst busy", cmd.busy,    0);
        chk("midrst rx",   cmd.rx_data, 0);
        reset = 1'b0;
        repeat (800) @(negedge clk);
        chk("midrst no_done", done_total - d0, 0);

        run_frame("after_rst", 8'hA5, 4'd3, {56'h0, 8'hF0, 8'h3C}, 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
